// File: rtl/al_bram_fifo_pkg.sv
// Shared constants and helpers for the al_bram_fifo block.
package al_bram_fifo_pkg;

  // Read latency from accepted rd_en to dout_vld, without / with output register.
  localparam int unsigned RD_LAT_NOREG  = 1;
  localparam int unsigned RD_LAT_OUTREG = 2;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/al_bram_fifo_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The array itself is never reset; only the read data register is cleared.
module al_bram_fifo_mem
  import al_bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/al_bram_fifo.sv
// Synchronous FIFO on a block-RAM style store.
// Controller (pointers, count, flags, strobes) lives here; storage is al_bram_fifo_mem.
// Optional macro AL_BRAM_FIFO_OUTREG_EN adds an output register after the RAM
// read port (read latency 2 instead of 1); flag and strobe timing is unchanged.
module al_bram_fifo
  import al_bram_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 9,
  parameter  int unsigned ADDR_WIDTH   = 10,
  parameter  int unsigned DATA_DEPTH   = 2 ** ADDR_WIDTH,
  parameter  int unsigned AFULL_LEVEL  = DATA_DEPTH - 4,
  parameter  int unsigned AEMPTY_LEVEL = 4,
  localparam int unsigned CNT_W        = cnt_width(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

`ifdef AL_BRAM_FIFO_OUTREG_EN
  localparam int unsigned RD_LAT = RD_LAT_OUTREG;
`else
  localparam int unsigned RD_LAT = RD_LAT_NOREG;
`endif

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CNT_W-1:0]      count_nxt;
  logic                  full_nxt;
  logic                  empty_nxt;
  logic                  afull_nxt;
  logic                  aempty_nxt;
  logic [RD_LAT-1:0]     vld_sr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Acceptance from pre-edge flags; reset blocks both ports so storage is untouched.
  always_comb begin
    wr_acc     = wr_en && !full && !rst;
    rd_acc     = rd_en && !empty && !rst;
    count_nxt  = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    full_nxt   = (count_nxt == CNT_W'(DATA_DEPTH));
    empty_nxt  = (count_nxt == '0);
    afull_nxt  = (32'(count_nxt) >= AFULL_LEVEL);
    aempty_nxt = (32'(count_nxt) <= AEMPTY_LEVEL);
  end

  // Pointers, occupancy, flags and reject strobes, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      count     <= count_nxt;
      full      <= full_nxt;
      empty     <= empty_nxt;
      afull     <= afull_nxt;
      aempty    <= aempty_nxt;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  al_bram_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

`ifdef AL_BRAM_FIFO_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_q;

  // Two-stage valid pipeline tracking RAM read then output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[0], rd_acc};
    end
  end

  // Output register loads only when the RAM stage holds a fresh word.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (vld_sr[0]) begin
      dout_q <= ram_rdata;
    end
  end

  assign dout = dout_q;
`else
  // Single-stage valid matching the RAM's registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= rd_acc;
    end
  end

  assign dout = ram_rdata;
`endif

  assign dout_vld = vld_sr[RD_LAT-1];

endmodule

// File: tb/tb_al_bram_fifo.sv
// Self-checking bench for al_bram_fifo against a queue-based reference model.
// Define AL_BRAM_FIFO_OUTREG_EN for both bench and RTL to check the latency-2 build.
module tb_al_bram_fifo;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 4;
`ifdef AL_BRAM_FIFO_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  al_bram_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_LEVEL  (AFL),
    .AEMPTY_LEVEL (AEL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .din       (din),
    .rd_en     (rd_en),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .full      (full),
    .empty     (empty),
    .afull     (afull),
    .aempty    (aempty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Reference model: stored words, read-event history by cycle, last delivered word.
  int q[$];
  int h_vld[2];
  int h_dat[2];
  int exp_dout;
  int exp_ovf;
  int exp_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    int sz;
    rst   = r;
    wr_en = w;
    din   = d;
    rd_en = rd;
    sz    = q.size();
    if (r) begin
      q.delete();
      h_vld    = '{0, 0};
      h_dat    = '{0, 0};
      exp_dout = 0;
      exp_ovf  = 0;
      exp_unf  = 0;
    end else begin
      exp_ovf  = (w && sz == DEPTH) ? 1 : 0;
      exp_unf  = (rd && sz == 0) ? 1 : 0;
      h_vld[1] = h_vld[0];
      h_dat[1] = h_dat[0];
      h_vld[0] = 0;
      if (rd && sz > 0) begin
        h_vld[0] = 1;
        h_dat[0] = q.pop_front();
      end
      if (w && sz < DEPTH) q.push_back(int'(d));
      if (h_vld[LAT-1] != 0) exp_dout = h_dat[LAT-1];
    end
    @(posedge clk);
    #1;
    chk("count",     32'(count),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("afull",     32'(afull),     32'(q.size() >= AFL));
    chk("aempty",    32'(aempty),    32'(q.size() <= AEL));
    chk("overflow",  32'(overflow),  32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
    chk("dout_vld",  32'(dout_vld),  32'(h_vld[LAT-1]));
    chk("dout",      32'(dout),      32'(exp_dout));
  endtask

  initial begin
    int wp;
    int rp;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    phase = "reset";
    step(1, 0, '0, 0);
    step(1, 1, 9'h055, 1);

    phase = "fill16";
    for (int i = 1; i <= 16; i++) step(0, 1, DW'(i), 0);

    phase = "drain16";
    for (int i = 0; i < 16; i++) step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    phase = "overflow";
    for (int i = 0; i < 16; i++) step(0, 1, DW'($urandom), 0);
    step(0, 1, 9'h1FF, 0);
    step(0, 1, 9'h1FE, 1);
    step(0, 0, '0, 0);

    phase = "underflow";
    while (q.size() > 0) step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 1, 9'h1AA, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    phase = "wrap";
    while (q.size() < 8) step(0, 1, DW'($urandom), 0);
    for (int i = 0; i < 40; i++) step(0, 1, DW'($urandom), 1);
    step(0, 0, '0, 0);

    phase = "rst_inflight";
    while (q.size() < 10) step(0, 1, DW'($urandom), 0);
    step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0);

    phase = "random";
    for (int blk = 0; blk < 6; blk++) begin
      wp = $urandom_range(20, 90);
      rp = $urandom_range(20, 90);
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 99) < wp),
             DW'($urandom),
             ($urandom_range(0, 99) < rp));
      end
    end
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
